// File: rtl/adc_lvds_tx_emulator.sv
// 2-lane SDR serializer emulating an ADC LVDS output (ln0/ln1/fco).
// Frames come from stream/ramp/checkerboard/idle sources; slip stretches one frame.
module adc_lvds_tx_emulator #(
   parameter int                    SAMPLE_W    = 16,
   parameter logic [SAMPLE_W/2-1:0] FCO_PATTERN = 8'hF0,
   parameter logic [SAMPLE_W-1:0]   IDLE_WORD   = 16'h0000,
   parameter logic [SAMPLE_W-1:0]   RAMP_INIT   = 16'h0000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic                slip,
   input  logic [SAMPLE_W-1:0] s_data,
   input  logic                s_valid,
   output logic                s_ready,
   output logic                ln0,
   output logic                ln1,
   output logic                fco,
   output logic                frame_start,
   output logic                underrun
);

   localparam int FB = SAMPLE_W / 2;
   localparam int CW = $clog2(FB + 1);
   localparam logic [SAMPLE_W-1:0] CB_A = {FB{2'b10}};
   localparam logic [SAMPLE_W-1:0] CB_B = ~CB_A;

   logic                r_en_d;
   logic                r_run;
   logic [CW-1:0]       r_cnt;
   logic                r_pend;
   logic [SAMPLE_W-1:0] r_hold;
   logic                r_hold_full;
   logic [SAMPLE_W-1:0] r_ramp;
   logic                r_cb;
   logic [FB-2:0]       r_sh1;
   logic [FB-2:0]       r_sh0;
   logic [FB-2:0]       r_fsh;
   logic                r_ln0;
   logic                r_ln1;
   logic                r_fco;
   logic                r_fs;
   logic                r_ur;

   logic                w_stream;
   logic                w_last;
   logic                w_stretch;
   logic                w_load;
   logic                w_xfer;
   logic [SAMPLE_W-1:0] w_word;
   logic                w_ur;
   logic [FB-1:0]       w_odd;
   logic [FB-1:0]       w_even;

   assign w_stream  = (mode == 2'd0);
   assign w_last    = (r_cnt == CW'(FB))
                    | ((r_cnt == CW'(FB - 1)) & ~r_pend);
   assign w_stretch = en & r_run & r_pend
                    & (r_cnt == CW'(FB - 1));
   assign w_load    = en & r_en_d & (~r_run | w_last);
   assign s_ready   = rst_n & en & w_stream
                    & (~r_hold_full | w_load);
   assign w_xfer    = s_valid & s_ready;

   assign ln0         = r_ln0;
   assign ln1         = r_ln1;
   assign fco         = r_fco;
   assign frame_start = r_fs;
   assign underrun    = r_ur;

   // select the word loaded at the frame boundary
   always_comb begin
      w_word = IDLE_WORD;
      w_ur   = 1'b0;
      unique case (mode)
         2'd0: begin
            if (r_hold_full) begin
               w_word = r_hold;
            end else if (s_valid) begin
               w_word = s_data;
            end else begin
               w_ur = 1'b1;
            end
         end
         2'd1: w_word = r_ramp;
         2'd2: w_word = r_cb ? CB_B : CB_A;
         2'd3: w_word = IDLE_WORD;
         default: w_word = IDLE_WORD;
      endcase
   end

   // split the word into odd (lane 1) and even (lane 0) bits
   always_comb begin
      w_odd  = '0;
      w_even = '0;
      for (int i = 0; i < FB; i++) begin
         w_odd[i]  = w_word[2*i+1];
         w_even[i] = w_word[2*i];
      end
   end

   // remember en from the previous cycle to detect start-up
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en_d <= 1'b0;
      end else begin
         r_en_d <= en;
      end
   end

   // one pending slip request, consumed by the stretch cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= 1'b0;
      end else if (w_stretch) begin
         r_pend <= 1'b0;
      end else if (en & slip) begin
         r_pend <= 1'b1;
      end
   end

   // bit counter, shifters and registered lane outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run <= 1'b0;
         r_cnt <= '0;
         r_sh1 <= '0;
         r_sh0 <= '0;
         r_fsh <= '0;
         r_ln0 <= 1'b0;
         r_ln1 <= 1'b0;
         r_fco <= 1'b0;
         r_fs  <= 1'b0;
         r_ur  <= 1'b0;
      end else if (!en) begin
         r_run <= 1'b0;
         r_cnt <= '0;
         r_ln0 <= 1'b0;
         r_ln1 <= 1'b0;
         r_fco <= 1'b0;
         r_fs  <= 1'b0;
         r_ur  <= 1'b0;
      end else if (w_load) begin
         r_run <= 1'b1;
         r_cnt <= '0;
         r_sh1 <= w_odd[FB-2:0];
         r_sh0 <= w_even[FB-2:0];
         r_fsh <= FCO_PATTERN[FB-2:0];
         r_ln1 <= w_odd[FB-1];
         r_ln0 <= w_even[FB-1];
         r_fco <= FCO_PATTERN[FB-1];
         r_fs  <= 1'b1;
         r_ur  <= w_ur;
      end else if (w_stretch) begin
         r_cnt <= CW'(FB);
         r_fco <= 1'b0;
         r_fs  <= 1'b0;
         r_ur  <= 1'b0;
      end else if (r_run) begin
         r_cnt <= r_cnt + CW'(1);
         r_ln1 <= r_sh1[FB-2];
         r_ln0 <= r_sh0[FB-2];
         r_fco <= r_fsh[FB-2];
         r_sh1 <= {r_sh1[FB-3:0], 1'b0};
         r_sh0 <= {r_sh0[FB-3:0], 1'b0};
         r_fsh <= {r_fsh[FB-3:0], 1'b0};
         r_fs  <= 1'b0;
         r_ur  <= 1'b0;
      end else begin
         r_ln0 <= 1'b0;
         r_ln1 <= 1'b0;
         r_fco <= 1'b0;
         r_fs  <= 1'b0;
         r_ur  <= 1'b0;
      end
   end

   // holding register: drains at stream loads, fills on spare transfers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else if (w_load & w_stream & r_hold_full) begin
         r_hold_full <= w_xfer;
         if (w_xfer) begin
            r_hold <= s_data;
         end
      end else if (w_xfer & ~w_load) begin
         r_hold_full <= 1'b1;
         r_hold      <= s_data;
      end
   end

   // ramp and checkerboard sources advance only when they are loaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ramp <= RAMP_INIT;
         r_cb   <= 1'b0;
      end else if (w_load) begin
         if (mode == 2'd1) begin
            r_ramp <= r_ramp + 1'b1;
         end
         if (mode == 2'd2) begin
            r_cb <= ~r_cb;
         end
      end
   end

endmodule

// File: tb/tb_adc_lvds_tx_emulator.sv
// Bench for adc_lvds_tx_emulator: frame-level model plus
// directed literal checks of serial patterns and timing.
module tb_adc_lvds_tx_emulator;

   localparam logic [7:0]  FCO  = 8'hF0;
   localparam logic [15:0] IDLE = 16'h0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        slip = 1'b0;
   logic [15:0] s_data = 16'h0000;
   logic        s_valid = 1'b0;
   logic        s_ready, ln0, ln1, fco, frame_start, underrun;
   logic        w_rdy, w_ln0, w_ln1, w_fco, w_fs, w_ur;

   int n_pass = 0;
   int n_tot = 0;
   int n_prt = 0;
   int cyc = 0;

   adc_lvds_tx_emulator dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .mode(mode), .slip(slip),
      .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .ln0(ln0), .ln1(ln1),
      .fco(fco), .frame_start(frame_start),
      .underrun(underrun)
   );

   adc_lvds_tx_emulator #(.RAMP_INIT(16'hFFFE)) u_wrap (
      .clk(clk), .rst_n(rst_n), .en(en),
      .mode(2'd1), .slip(1'b0),
      .s_data(16'h0000), .s_valid(1'b0),
      .s_ready(w_rdy), .ln0(w_ln0), .ln1(w_ln1),
      .fco(w_fco), .frame_start(w_fs),
      .underrun(w_ur)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm,
                      input logic [31:0] a,
                      input logic [31:0] e);
      n_tot++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, a, e);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic l1; logic l0; logic f; logic fs; logic ur;
   } slot_t;

   slot_t       m_cur = '0;
   slot_t       m_q[$];
   logic [15:0] m_hold[$];
   logic [15:0] m_ramp = 16'h0000;
   bit          m_cb = 1'b0;
   bit          m_pend = 1'b0;
   bit          m_enp = 1'b0;
   bit          m_run = 1'b0;

   function automatic bit m_load_now();
      return en && m_enp &&
             (!m_run || (m_q.size() == 0 && !m_pend));
   endfunction

   function automatic bit m_ready();
      return rst_n && en && mode == 2'd0 &&
             (m_hold.size() == 0 || m_load_now());
   endfunction

   task automatic m_push_word(input logic [15:0] w,
                              input bit ur);
      slot_t s;
      logic [7:0] fp;
      fp = FCO;
      for (int k = 0; k < 8; k++) begin
         s.l1 = w[15-2*k];
         s.l0 = w[14-2*k];
         s.f  = fp[7-k];
         s.fs = (k == 0);
         s.ur = (k == 0) && ur;
         m_q.push_back(s);
      end
   endtask

   task automatic m_step();
      bit xf, ld, st, ur;
      logic [15:0] w;
      if (!rst_n) begin
         m_cur = '0; m_q.delete(); m_hold.delete();
         m_ramp = 16'h0000; m_cb = 0; m_pend = 0;
         m_enp = 0; m_run = 0;
         return;
      end
      xf = s_valid && m_ready();
      ld = m_load_now();
      st = 0;
      if (!en) begin
         m_cur = '0; m_q.delete(); m_run = 0;
      end else if (ld) begin
         ur = 0;
         w = IDLE;
         case (mode)
            2'd0: begin
               if (m_hold.size() != 0) begin
                  w = m_hold.pop_front();
                  if (xf) m_hold.push_back(s_data);
               end else if (s_valid) w = s_data;
               else ur = 1;
            end
            2'd1: begin w = m_ramp; m_ramp++; end
            2'd2: begin
               w = m_cb ? 16'h5555 : 16'hAAAA;
               m_cb = !m_cb;
            end
            default: w = IDLE;
         endcase
         m_push_word(w, ur);
         m_cur = m_q.pop_front();
         m_run = 1;
      end else if (m_run && m_q.size() == 0) begin
         m_cur.f = 0; m_cur.fs = 0; m_cur.ur = 0;
         m_pend = 0;
         st = 1;
      end else if (m_run) begin
         m_cur = m_q.pop_front();
      end else begin
         m_cur = '0;
      end
      if (!ld && xf) m_hold.push_back(s_data);
      if (!st && en && slip) m_pend = 1;
      m_enp = en;
   endtask

   initial forever begin
      @(posedge clk);
      m_step();
   end

   // per-cycle comparison against the model
   initial forever begin
      logic [5:0] act, exp;
      @(negedge clk);
      act = {ln1, ln0, fco, frame_start, underrun, s_ready};
      exp = rst_n ? {m_cur, m_ready()} : 6'b0;
      n_tot++;
      if (act === exp) n_pass++;
      else if (n_prt < 40) begin
         n_prt++;
         $display("FAIL cycle %0d outputs: got %b want %b",
                  cyc, act, exp);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic reset_dut();
      en = 0;
      rst_n = 0;
      tick(); tick();
      rst_n = 1;
      tick();
   endtask

   task automatic cap_frame(input bit wr,
                            output logic [7:0] b1,
                            output logic [7:0] b0,
                            output logic [7:0] f,
                            output logic ur);
      bit ok;
      ok = 0; b1 = 0; b0 = 0; f = 0; ur = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = wr ? w_fs : frame_start;
      end
      if (!ok) begin
         n_tot++;
         $display("FAIL frame_timeout: got none want frame_start");
         return;
      end
      ur = wr ? w_ur : underrun;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         b1[7-k] = wr ? w_ln1 : ln1;
         b0[7-k] = wr ? w_ln0 : ln0;
         f[7-k]  = wr ? w_fco : fco;
      end
   endtask

   task automatic frame_word(input bit wr,
                             output logic [15:0] w,
                             output logic ur);
      logic [7:0] b1, b0, f;
      cap_frame(wr, b1, b0, f, ur);
      for (int k = 0; k < 8; k++) begin
         w[15-2*k] = b1[7-k];
         w[14-2*k] = b0[7-k];
      end
   endtask

   task automatic wait_fs(output int t);
      bit ok;
      ok = 0;
      t = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = frame_start;
      end
      if (!ok) begin
         n_tot++;
         $display("FAIL fs_timeout: got none want frame_start");
      end
      t = cyc;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [7:0]  b1, b0, f;
      logic [15:0] w;
      logic        ur;
      int          t0, t1, t2, t3, n;

      tick(); tick();
      #1;
      chk("reset_outputs",
          {ln1, ln0, fco, frame_start, underrun, s_ready}, 0);
      rst_n = 1;
      tick();

      // single stream word
      mode = 2'd0; s_data = 16'hA5C3; s_valid = 1; en = 1;
      cap_frame(0, b1, b0, f, ur);
      chk("t1_ln1", b1, 8'hC9);
      chk("t1_ln0", b0, 8'h39);
      chk("t1_fco", f, 8'hF0);
      chk("t1_underrun", ur, 0);
      tick();
      s_valid = 0; en = 0;
      tick(); tick();

      // back-to-back stream words, then underrun
      reset_dut();
      mode = 2'd0; s_data = 16'h0001; s_valid = 1; en = 1;
      fork
         begin
            for (int c = 0; c < 200; c++) begin
               @(negedge clk);
               if (s_ready) begin
                  tick();
                  if (s_data == 16'h0004) begin
                     s_valid = 0;
                     break;
                  end
                  s_data = s_data + 16'h1;
               end
            end
         end
         begin
            for (int i = 1; i <= 4; i++) begin
               frame_word(0, w, ur);
               chk("t2_word", w, i);
               chk("t2_no_underrun", ur, 0);
            end
         end
      join
      frame_word(0, w, ur);
      chk("t3_idle_word", w, IDLE);
      chk("t3_underrun", ur, 1);
      tick();
      s_data = 16'h1234; s_valid = 1;
      frame_word(0, w, ur);
      chk("t3_underrun_again", ur, 1);
      frame_word(0, w, ur);
      chk("t3_restored_word", w, 16'h1234);
      chk("t3_restored_no_ur", ur, 0);
      tick();
      s_valid = 0;

      // checkerboard
      reset_dut();
      mode = 2'd2; en = 1;
      cap_frame(0, b1, b0, f, ur);
      chk("t4_cb_a_ln1", b1, 8'hFF);
      chk("t4_cb_a_ln0", b0, 8'h00);
      cap_frame(0, b1, b0, f, ur);
      chk("t4_cb_b_ln1", b1, 8'h00);
      chk("t4_cb_b_ln0", b0, 8'hFF);

      // ramp from reset
      reset_dut();
      mode = 2'd1; en = 1;
      for (int i = 0; i < 4; i++) begin
         frame_word(0, w, ur);
         chk("t4_ramp", w, i);
      end

      // ramp wrap on the preset instance
      reset_dut();
      en = 1;
      frame_word(1, w, ur);
      chk("t4_wrap_fffe", w, 16'hFFFE);
      frame_word(1, w, ur);
      chk("t4_wrap_ffff", w, 16'hFFFF);
      frame_word(1, w, ur);
      chk("t4_wrap_0000", w, 16'h0000);

      // idle-word mode
      tick();
      mode = 2'd3;
      frame_word(0, w, ur);
      frame_word(0, w, ur);
      chk("mode3_word", w, IDLE);
      chk("mode3_no_ur", ur, 0);

      // slip: two pulses, one stretch
      mode = 2'd2;
      wait_fs(t0);
      wait_fs(t0);
      tick(); tick(); tick();
      slip = 1; tick();
      slip = 0; tick();
      slip = 1; tick();
      slip = 0;
      wait_fs(t1);
      wait_fs(t2);
      wait_fs(t3);
      chk("t5_stretched_len", t1 - t0, 9);
      chk("t5_next_len", t2 - t1, 8);
      chk("t5_after_len", t3 - t2, 8);

      // en dropped mid-frame, then restored
      tick(); tick();
      en = 0;
      tick(); tick(); tick();
      en = 1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (frame_start) break;
         n++;
      end
      chk("en_restart_delay", n, 2);

      // reset mid-frame with hold full
      mode = 2'd1;
      frame_word(0, w, ur);
      tick();
      mode = 2'd0; s_data = 16'hBEEF; s_valid = 1;
      wait_fs(t0);
      wait_fs(t0);
      tick(); tick(); tick(); tick();
      rst_n = 0; s_valid = 0;
      #1;
      chk("t6_reset_outputs",
          {ln1, ln0, fco, frame_start, underrun}, 0);
      chk("t6_reset_ready", s_ready, 0);
      en = 0;
      tick(); tick();
      rst_n = 1;
      tick();
      en = 1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (frame_start) break;
         n++;
      end
      chk("t6_first_fs", n, 2);
      chk("t6_hold_empty", underrun, 1);
      tick();
      mode = 2'd1;
      frame_word(0, w, ur);
      chk("t6_ramp_zero", w, 16'h0000);
      tick();
      en = 0;
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
